// File: rtl/jtvigil_obj.sv
// Vigilante sprite line renderer: scans object RAM for sprites on the next line,
// fetches their rows from ROM into a double line buffer, and streams the other half out.
module jtvigil_obj #(
    parameter int OBJ_N = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic        line,
    input  logic [8:0]  vrender,
    input  logic [8:0]  hdump,
    output logic [7:0]  oram_addr,
    input  logic [7:0]  oram_dout,
    output logic        rom_cs,
    output logic [17:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_ok,
    output logic [7:0]  pxl
);
    localparam logic [4:0] LAST = 5'(OBJ_N - 1);

    typedef enum logic [2:0] {IDLE, READ, CHECK, REQ, DRAW, NEXT} state_t;
    state_t state_reg, state_next;

    logic        buf_sel_reg, disp_sel_reg;
    logic [4:0]  entry_reg;
    logic [2:0]  rd_cnt_reg, draw_cnt_reg;
    logic [7:0]  y_reg, attr_reg;
    logic [11:0] code_reg, code_eff_reg;
    logic [8:0]  x_reg;
    logic [3:0]  row_reg;
    logic        k_reg, rom_cs_reg, hold_reg;
    logic [31:0] data_reg;
    logic [7:0]  rd_q [2];

    logic [8:0]  height, ydiff, yr, px;
    logic        hit, take, draw_we, hflip;
    logic [2:0]  idx;
    logic [3:0]  colour;

    assign hflip  = attr_reg[4];
    assign height = 9'd16 << attr_reg[7:6];
    assign ydiff  = vrender - {1'b0, y_reg};
    assign hit    = ydiff < height;
    assign yr     = attr_reg[5] ? height - 9'd1 - ydiff : ydiff;

    assign oram_addr = {entry_reg, rd_cnt_reg};
    assign rom_cs    = rom_cs_reg;
    assign rom_addr  = {code_eff_reg, row_reg, k_reg ^ hflip, 1'b0};

    // Data must be stable for two clocks at one address before rom_ok is trusted
    assign take = rom_cs_reg && hold_reg && rom_ok;

    assign idx     = hflip ? draw_cnt_reg : ~draw_cnt_reg;
    assign colour  = {data_reg[{2'b11, idx}], data_reg[{2'b10, idx}],
                      data_reg[{2'b01, idx}], data_reg[{2'b00, idx}]};
    assign px      = x_reg + {5'd0, k_reg, draw_cnt_reg};
    assign draw_we = (state_reg == DRAW) && (colour != 4'd0) && !px[8];

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  state_next = IDLE;
            READ:  if (rd_cnt_reg == 3'd6) state_next = CHECK;
            CHECK: state_next = hit ? REQ : NEXT;
            REQ:   if (take) state_next = DRAW;
            DRAW:  if (draw_cnt_reg == 3'd7) state_next = k_reg ? NEXT : REQ;
            NEXT:  state_next = (entry_reg == LAST) ? IDLE : READ;
            default: state_next = IDLE;
        endcase
        // A new line always restarts the scan, whatever was in progress
        if (line) state_next = READ;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_sel_reg  <= 1'b0;
            entry_reg    <= 5'd0;
            rd_cnt_reg   <= 3'd0;
            draw_cnt_reg <= 3'd0;
            y_reg        <= 8'd0;
            attr_reg     <= 8'd0;
            code_reg     <= 12'd0;
            code_eff_reg <= 12'd0;
            x_reg        <= 9'd0;
            row_reg      <= 4'd0;
            k_reg        <= 1'b0;
            rom_cs_reg   <= 1'b0;
            hold_reg     <= 1'b0;
            data_reg     <= 32'd0;
        end else begin
            case (state_reg)
                READ: begin
                    rd_cnt_reg <= rd_cnt_reg + 3'd1;
                    case (rd_cnt_reg)
                        3'd1: y_reg          <= oram_dout;
                        3'd2: attr_reg       <= oram_dout;
                        3'd3: code_reg[7:0]  <= oram_dout;
                        3'd4: code_reg[11:8] <= oram_dout[3:0];
                        3'd5: x_reg[7:0]     <= oram_dout;
                        3'd6: x_reg[8]       <= oram_dout[0];
                        default: ;
                    endcase
                end
                CHECK: begin
                    code_eff_reg <= code_reg + {9'd0, yr[6:4]};
                    row_reg      <= yr[3:0];
                    k_reg        <= 1'b0;
                    if (hit) begin
                        rom_cs_reg <= 1'b1;
                        hold_reg   <= 1'b0;
                    end
                end
                REQ: begin
                    if (take) begin
                        data_reg     <= rom_data;
                        rom_cs_reg   <= 1'b0;
                        draw_cnt_reg <= 3'd0;
                    end else begin
                        hold_reg <= 1'b1;
                    end
                end
                DRAW: begin
                    draw_cnt_reg <= draw_cnt_reg + 3'd1;
                    if (draw_cnt_reg == 3'd7 && !k_reg) begin
                        k_reg      <= 1'b1;
                        rom_cs_reg <= 1'b1;
                        hold_reg   <= 1'b0;
                    end
                end
                NEXT: begin
                    entry_reg  <= entry_reg + 5'd1;
                    rd_cnt_reg <= 3'd0;
                end
                default: ;
            endcase
            if (line) begin
                buf_sel_reg <= ~buf_sel_reg;
                entry_reg   <= 5'd0;
                rd_cnt_reg  <= 3'd0;
                rom_cs_reg  <= 1'b0;
                hold_reg    <= 1'b0;
            end
        end
    end

    // Each bank sees exactly one writer per clock: the renderer or the display clear
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [7:0] mem [256];

            always_ff @(posedge clk) begin
                if (buf_sel_reg == 1'(gi)) begin
                    if (draw_we) mem[px[7:0]] <= {attr_reg[3:0], colour};
                end else if (pxl_cen) begin
                    mem[hdump[7:0]] <= 8'd0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n)       rd_q[gi] <= 8'd0;
                else if (pxl_cen) rd_q[gi] <= mem[hdump[7:0]];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n)       disp_sel_reg <= 1'b1;
        else if (pxl_cen) disp_sel_reg <= ~buf_sel_reg;
    end

    assign pxl = disp_sel_reg ? rd_q[1] : rd_q[0];

    logic unused_ok;
    assign unused_ok = &{1'b0, hdump[8], yr[8:7]};
endmodule

// File: tb/tb_jtvigil_obj.sv
// Bench for jtvigil_obj: object RAM / ROM models, a reference line renderer and
// a rom_addr scoreboard, driven by a vector table plus abort and reset sequences.
module tb_jtvigil_obj;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pxl_cen = 1'b0;
    logic        line = 1'b0;
    logic [8:0]  vrender = 9'd0;
    logic [8:0]  hdump = 9'd0;
    logic [7:0]  oram_addr;
    logic [7:0]  oram_dout = 8'd0;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [31:0] rom_data = 32'd0;
    logic        rom_ok = 1'b0;
    logic [7:0]  pxl;

    always #5 clk = ~clk;

    jtvigil_obj #(.OBJ_N(32)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .line(line),
        .vrender(vrender), .hdump(hdump), .oram_addr(oram_addr),
        .oram_dout(oram_dout), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok), .pxl(pxl)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  oram [256];
    logic [31:0] rom_mem [int];
    bit          rom_ok_en = 1'b1;

    always @(posedge clk) oram_dout <= oram[oram_addr];

    function automatic logic [31:0] rom_word(input logic [17:0] a);
        if (rom_mem.exists(int'(a))) return rom_mem[int'(a)];
        return 32'd0;
    endfunction

    // ROM responder: rom_ok may be stale-high on the first clock with junk data
    int          cs_cnt = 0;
    logic        prev_cs = 1'b0;
    logic [17:0] prev_addr = 18'd0;
    logic [17:0] obs_addr [512];
    int          obs_n = 0;
    always @(negedge clk) begin
        if (rom_cs && prev_cs && rom_addr == prev_addr) cs_cnt++;
        else cs_cnt = 0;
        prev_cs   = rom_cs;
        prev_addr = rom_addr;
        rom_ok    = rom_ok_en && rom_cs;
        rom_data  = (cs_cnt >= 1) ? rom_word(rom_addr) : 32'h5A5A5A5A;
        if (rom_cs && cs_cnt == 0 && obs_n < 512) begin
            obs_addr[obs_n] = rom_addr;
            obs_n++;
        end
    end

    initial begin
        #900000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    logic [7:0]  exp_draw [256];
    logic [7:0]  exp_disp [256];
    logic [7:0]  cap [256];
    logic [17:0] exp_q [$];
    int          obs_rd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input int e, input logic [7:0] y, input logic [7:0] attr,
                              input logic [11:0] code, input logic [8:0] x);
        oram[e*8+0] = y;
        oram[e*8+1] = attr;
        oram[e*8+2] = code[7:0];
        oram[e*8+3] = {4'hA, code[11:8]};
        oram[e*8+4] = x[7:0];
        oram[e*8+5] = {7'h55, x[8]};
        oram[e*8+6] = 8'hFF;
        oram[e*8+7] = 8'hFF;
    endtask

    task automatic load_misses();
        for (int e = 0; e < 32; e++) load_entry(e, 8'hC0, 8'h00, 12'h000, 9'h000);
    endtask

    // Reference renderer: walks the 16 screen columns and maps each back to a sprite pixel
    task automatic render(input logic [8:0] vr);
        logic [7:0]  y, at;
        logic [11:0] cd;
        logic [31:0] w;
        logic [3:0]  clr;
        int x, h, yd, yr, ce, a0, a1, sc, i, col;
        for (int c = 0; c < 256; c++) exp_draw[c] = 8'd0;
        for (int e = 0; e < 32; e++) begin
            y  = oram[e*8];
            at = oram[e*8+1];
            cd = {oram[e*8+3][3:0], oram[e*8+2]};
            x  = int'({oram[e*8+5][0], oram[e*8+4]});
            h  = 16 << at[7:6];
            yd = (int'(vr) - int'(y)) & 511;
            if (yd < h) begin
                yr = at[5] ? h - 1 - yd : yd;
                ce = (int'(cd) + yr / 16) & 12'hFFF;
                a0 = ce * 64 + (yr % 16) * 4;
                a1 = a0 + 2;
                if (at[4]) begin exp_q.push_back(18'(a1)); exp_q.push_back(18'(a0)); end
                else       begin exp_q.push_back(18'(a0)); exp_q.push_back(18'(a1)); end
                for (int c = 0; c < 16; c++) begin
                    sc  = at[4] ? 15 - c : c;
                    w   = rom_word(18'(sc < 8 ? a0 : a1));
                    i   = sc % 8;
                    clr = {w[31-i], w[23-i], w[15-i], w[7-i]};
                    col = x + c;
                    if (col < 256 && clr != 4'd0) exp_draw[col] = {at[3:0], clr};
                end
            end
        end
    endtask

    task automatic pulse_line(input logic [8:0] vr);
        vrender = vr;
        line = 1'b1;
        tick();
        line = 1'b0;
    endtask

    task automatic sweep(input bit check);
        for (int h = 0; h < 256; h++) begin
            hdump = 9'(h);
            pxl_cen = 1'b1;
            tick();
            pxl_cen = 1'b0;
            cap[h] = pxl;
            if (check) chk($sformatf("pxl[%02h]", h), 32'(pxl), 32'(exp_disp[h]));
            repeat (3) tick();
        end
        repeat (4) tick();
    endtask

    task automatic drain();
        logic [17:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_n) begin
                chk("rom_addr", 32'(obs_addr[obs_rd]), 32'(e));
                obs_rd++;
            end else begin
                chk("rom_req_missing", 32'(obs_n), 32'(obs_rd + 1));
            end
        end
    endtask

    task automatic do_line(input logic [8:0] vr, input bit check);
        exp_disp = exp_draw;
        render(vr);
        pulse_line(vr);
        sweep(check);
        drain();
    endtask

    typedef struct {
        logic [7:0]  y;
        logic [7:0]  attr;
        logic [11:0] code;
        logic [8:0]  x;
        logic [8:0]  vr;
        logic        hit;
        logic [17:0] addr;
        logic [7:0]  col;
        logic [7:0]  px;
    } vec_t;

    vec_t vecs [7];
    int   n, start_idx;

    initial begin
        rom_mem[32'h148] = 32'hFF000000;
        rom_mem[32'h4E8] = 32'h000000FF;
        rom_mem[32'h4EA] = 32'h00FF0000;
        rom_mem[32'h1FC] = 32'h80808080;
        rom_mem[32'h000] = 32'hF0000000;
        rom_mem[32'h800] = 32'hFF000000;
        rom_mem[32'h802] = 32'hFF000000;

        //        y      {sz,vf,hf,pal} code     x       vr      hit  addr      col    px
        vecs[0] = '{8'h40, 8'h03, 12'h005, 9'h010, 9'h042, 1'b1, 18'h148, 8'h10, 8'h38};
        vecs[1] = '{8'h40, 8'h13, 12'h005, 9'h010, 9'h042, 1'b1, 18'h14A, 8'h1F, 8'h38};
        vecs[2] = '{8'h00, 8'hA5, 12'h010, 9'h040, 9'h005, 1'b1, 18'h4E8, 8'h48, 8'h54};
        vecs[3] = '{8'h40, 8'h0A, 12'h007, 9'h080, 9'h04F, 1'b1, 18'h1FC, 8'h80, 8'hAF};
        vecs[4] = '{8'h40, 8'h0A, 12'h007, 9'h080, 9'h050, 1'b0, 18'h000, 8'h80, 8'h00};
        vecs[5] = '{8'h20, 8'h46, 12'hFFF, 9'h030, 9'h030, 1'b1, 18'h000, 8'h30, 8'h68};
        vecs[6] = '{8'h40, 8'h07, 12'h005, 9'h1F8, 9'h042, 1'b1, 18'h148, 8'hF8, 8'h00};

        load_misses();
        for (int c = 0; c < 256; c++) exp_draw[c] = 8'd0;
        repeat (3) tick();
        chk("reset_pxl", 32'(pxl), 32'h0);
        chk("reset_rom_cs", 32'(rom_cs), 32'h0);
        chk("reset_oram_addr", 32'(oram_addr), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        do_line(9'h100, 1'b0);
        do_line(9'h100, 1'b0);

        for (int r = 0; r < 7; r++) begin
            load_misses();
            load_entry(0, vecs[r].y, vecs[r].attr, vecs[r].code, vecs[r].x);
            start_idx = obs_n;
            do_line(vecs[r].vr, 1'b1);
            if (vecs[r].hit) chk($sformatf("tbl%0d_first_addr", r), 32'(obs_addr[start_idx]), 32'(vecs[r].addr));
            else             chk($sformatf("tbl%0d_no_req", r), 32'(obs_n), 32'(start_idx));
            do_line(9'h100, 1'b1);
            chk($sformatf("tbl%0d_px", r), 32'(cap[vecs[r].col]), 32'(vecs[r].px));
        end

        // Clipping at the right edge and later-entry priority
        load_misses();
        load_entry(0, 8'h40, 8'h01, 12'h020, 9'h0FC);
        load_entry(1, 8'h40, 8'h02, 12'h020, 9'h0F8);
        do_line(9'h040, 1'b1);
        do_line(9'h100, 1'b1);
        chk("clip_prio_fc", 32'(cap[8'hFC]), 32'h28);
        chk("clip_prio_f8", 32'(cap[8'hF8]), 32'h28);
        chk("clip_no_wrap", 32'(cap[8'h00]), 32'h00);

        // Abort while a ROM request is pending
        load_misses();
        do_line(9'h100, 1'b1);
        load_entry(0, 8'h40, 8'h03, 12'h005, 9'h010);
        rom_ok_en = 1'b0;
        pulse_line(9'h042);
        n = 0;
        while (!rom_cs && n < 200) begin tick(); n++; end
        chk("abort_req_seen", 32'(rom_cs), 32'h1);
        repeat (3) tick();
        exp_q.push_back(18'h148);
        exp_disp = exp_draw;
        render(9'h042);
        pulse_line(9'h042);
        chk("abort_rom_cs", 32'(rom_cs), 32'h0);
        chk("abort_oram_b0", 32'(oram_addr), 32'h00);
        tick();
        chk("abort_oram_b1", 32'(oram_addr), 32'h01);
        rom_ok_en = 1'b1;
        sweep(1'b1);
        drain();
        do_line(9'h100, 1'b1);

        // Reset in the middle of a DRAW
        pulse_line(9'h042);
        exp_q.push_back(18'h148);
        n = 0;
        while (!rom_cs && n < 200) begin tick(); n++; end
        while (rom_cs && n < 400) begin tick(); n++; end
        chk("rst_draw_reached", 32'(n < 400), 32'h1);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid_pxl", 32'(pxl), 32'h0);
        chk("rst_mid_rom_cs", 32'(rom_cs), 32'h0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("rst_idle_rom_cs", 32'(rom_cs), 32'h0);
        chk("rst_idle_oram", 32'(oram_addr), 32'h0);
        drain();
        load_misses();
        do_line(9'h100, 1'b0);
        do_line(9'h100, 1'b0);
        load_entry(0, 8'h40, 8'h03, 12'h005, 9'h010);
        do_line(9'h042, 1'b1);
        do_line(9'h100, 1'b1);
        chk("rst_resume_px", 32'(cap[8'h17]), 32'h38);

        chk("rom_extra_req", 32'(obs_n), 32'(obs_rd));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
